nav_position_unit: RTL and testbench
====================================

Name: nav_position_unit

Overview:
- Multi-axis spaceship position integrator for the command module; generalises the per-axis position register to AXES axes of width K.
- Adds signed (directional) sublight motion, saturation at range bounds, and a timed warp-jump sequence with busy/done handshake.
- All axes share one state machine and one speed selection; direction and limit flags are per axis.
- Feeds navigation/display logic with a flat position bus.

Parameters:
- K, 16, bits per axis coordinate (unsigned, min 2).
- AXES, 3, number of axes (min 1).
- ATTACK_SPEED, 1, K-bit step per cycle in attack mode.
- DEFENSE_SPEED, 1, K-bit step per cycle in defense mode.
- STEALTH_SPEED, 1, K-bit step per cycle in stealth mode.
- WARP_CYCLES, 4, charge cycles before a jump lands (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- mode  in  4  one-hot speed select: 0001 zero, 0010 attack, 0100 defense, 1000 stealth.
- move_en  in  1  enable sublight motion this cycle.
- dir  in  AXES  per-axis direction: 0 = increment, 1 = decrement.
- home  in  1  synchronous return of all axes to 0.
- jump_req  in  1  request warp jump to jump_position.
- jump_position  in  AXES*K  jump target; axis i at bits [i*K +: K].
- position  out  AXES*K  current position, same packing.
- jump_busy  out  1  high in CHARGE and WARP.
- jump_done  out  1  one-cycle pulse when a jump lands.
- at_limit  out  AXES  per-axis flag: last move clamped at a bound.

Behaviour:
- Reset (async, rst=1):
  - position=0, state=CRUISE, counter=0, latched target=0.
  - jump_busy=0, jump_done=0, at_limit=0.
  - Reset asserted mid-jump discards the jump.
- Velocity: mux of the mode speeds.
  - 0001, 0000, or any non-one-hot mode gives 0.
  - Speeds are unsigned K bits.
- FSM states: CRUISE, CHARGE, WARP.
- CRUISE, evaluated each edge in priority order home > jump_req > move_en:
  - home: all axes=0, at_limit=0.
  - jump_req: latch jump_position into the target register; counter=WARP_CYCLES-1; go to CHARGE. Position holds this edge.
  - move_en:
    - dir=0 axis: pos+vel in K+1 bits; overflow clamps to 2^K-1.
    - dir=1 axis: pos-vel; borrow clamps to 0.
    - at_limit[i]=1 iff axis i clamped this edge, else 0.
  - None of the above: position and at_limit hold.
- CHARGE:
  - Position frozen; move_en and jump_req ignored.
  - counter==0 -> WARP, else counter--.
  - home aborts: axes=0, go to CRUISE, no jump_done.
- WARP:
  - On the edge: position=latched target, jump_done=1, at_limit=0, go to CRUISE.
  - home in this state wins: axes=0, no jump_done.
- Jump latency:
  - Request sampled at edge 0; target visible after edge WARP_CYCLES+1; jump_done high for the cycle following that edge.
  - jump_busy rises after edge 0 and falls after the landing edge.
- jump_done is registered; it clears on the next edge.
- Requests during busy are dropped, not queued. A jump_req held high in CRUISE after landing starts a new jump on the next edge.
- The target is latched at the request edge; later changes to jump_position do not affect an in-flight jump.
- vel=0 with move_en: position unchanged, at_limit=0.

Optional Feature:
- Macro: NAV_POSITION_WRAP_EN.
- Defined:
  - Sublight motion wraps modulo 2^K instead of saturating.
  - at_limit[i] pulses for one cycle on the edge where axis i wrapped.
- Undefined: saturation as specified above.
- Jump/home behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 mid-CHARGE -> position=0, jump_busy=0, jump_done=0 immediately (async), state CRUISE after release.
- Sublight: mode=0010, ATTACK_SPEED=3, dir=000, move_en=1 for 5 edges from 0 -> all axes=15; dir=010 for 2 more edges -> x=21, y=9, z=21.
- Saturation: x=0xFFFE, speed 3, dir=0 -> x=0xFFFF, at_limit[0]=1. With NAV_POSITION_WRAP_EN -> x=0x0001, at_limit[0] pulses.
- Jump: WARP_CYCLES=4, target {0x0249,0x0100,0x0010}, jump_req 1 cycle -> position unchanged for 4 edges, target after edge 5, jump_done high exactly 1 cycle. Change jump_position mid-charge -> original target lands.
- Abort/priority: home asserted in CHARGE -> axes=0, no jump_done. jump_req+home same edge in CRUISE -> home wins, no jump. jump_req during busy -> ignored.
- Mode decode: mode=0110 with move_en=1 -> position holds, at_limit=0.

Source files
------------

// File: rtl/nav_position_unit_if.sv
// nav_position_unit_if: command and status bundle between navigation control and nav_position_unit
interface nav_position_unit_if #(
    parameter int K    = 16,
    parameter int AXES = 3
);
    logic [3:0]        mode;
    logic              move_en;
    logic [AXES-1:0]   dir;
    logic              home;
    logic              jump_req;
    logic [AXES*K-1:0] jump_position;
    logic [AXES*K-1:0] position;
    logic              jump_busy;
    logic              jump_done;
    logic [AXES-1:0]   at_limit;

    modport master (
        output mode, move_en, dir, home, jump_req, jump_position,
        input  position, jump_busy, jump_done, at_limit
    );

    modport slave (
        input  mode, move_en, dir, home, jump_req, jump_position,
        output position, jump_busy, jump_done, at_limit
    );
endinterface

// File: rtl/nav_position_unit.sv
// nav_position_unit: multi-axis position integrator with saturating sublight motion and timed warp jumps; define NAV_POSITION_WRAP_EN for modulo-2^K motion
module nav_position_unit #(
    parameter int           K             = 16,
    parameter int           AXES          = 3,
    parameter logic [K-1:0] ATTACK_SPEED  = K'(1),
    parameter logic [K-1:0] DEFENSE_SPEED = K'(1),
    parameter logic [K-1:0] STEALTH_SPEED = K'(1),
    parameter int           WARP_CYCLES   = 4
) (
    input logic                clk,
    input logic                rst,
    nav_position_unit_if.slave bus
);
    localparam int CW = (WARP_CYCLES > 1) ? $clog2(WARP_CYCLES) : 1;
`ifdef NAV_POSITION_WRAP_EN
    localparam logic LIM_PULSE = 1'b1;
`else
    localparam logic LIM_PULSE = 1'b0;
`endif

    typedef enum logic [1:0] {CRUISE, CHARGE, WARP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [AXES*K-1:0] pos, pos_nxt, tgt, tgt_nxt, mv;
    logic [AXES-1:0]   lim, lim_nxt, clamp;
    logic              done, done_nxt;
    logic [K-1:0]      vel;

    // speed select: zero mode and any non-one-hot code stall the ship
    always_comb
        vel = bus.mode == 4'b0010 ? ATTACK_SPEED :
              bus.mode == 4'b0100 ? DEFENSE_SPEED :
              bus.mode == 4'b1000 ? STEALTH_SPEED : '0;

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        logic [K:0] sum, dif;
        assign sum      = {1'b0, pos[i*K +: K]} + {1'b0, vel};
        assign dif      = {1'b0, pos[i*K +: K]} - {1'b0, vel};
        assign clamp[i] = bus.dir[i] ? dif[K] : sum[K];
`ifdef NAV_POSITION_WRAP_EN
        assign mv[i*K +: K] = bus.dir[i] ? dif[K-1:0] : sum[K-1:0];
`else
        assign mv[i*K +: K] = bus.dir[i] ? (dif[K] ? '0 : dif[K-1:0])
                                         : (sum[K] ? '1 : sum[K-1:0]);
`endif
    end

    // next state: home overrides every state, then the per-state behaviour
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pos_nxt   = pos;
        tgt_nxt   = tgt;
        lim_nxt   = LIM_PULSE ? '0 : lim;
        done_nxt  = 1'b0;
        if (bus.home) begin
            pos_nxt   = '0;
            lim_nxt   = '0;
            state_nxt = CRUISE;
        end else begin
            case (state)
                CRUISE: begin
                    if (bus.jump_req) begin
                        tgt_nxt   = bus.jump_position;
                        cnt_nxt   = CW'(WARP_CYCLES - 1);
                        state_nxt = CHARGE;
                    end else if (bus.move_en) begin
                        pos_nxt = mv;
                        lim_nxt = clamp;
                    end
                end
                CHARGE: begin
                    if (cnt == '0) state_nxt = WARP;
                    else cnt_nxt = cnt - 1'b1;
                end
                WARP: begin
                    pos_nxt   = tgt;
                    lim_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = CRUISE;
                end
                default: state_nxt = CRUISE;
            endcase
        end
    end

    // state registers; reset discards any jump in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CRUISE;
            cnt   <= '0;
            pos   <= '0;
            tgt   <= '0;
            lim   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pos   <= pos_nxt;
            tgt   <= tgt_nxt;
            lim   <= lim_nxt;
            done  <= done_nxt;
        end
    end

    assign bus.position  = pos;
    assign bus.jump_busy = state != CRUISE;
    assign bus.jump_done = done;
    assign bus.at_limit  = lim;
endmodule

// File: tb/tb_nav_position_unit.sv
// tb_nav_position_unit: directed scoreboard bench for nav_position_unit
module tb_nav_position_unit;
  localparam logic [3:0] M0 = 4'b0001, MA = 4'b0010, MD = 4'b0100, MS = 4'b1000;
  typedef struct {
    string       tag;
    logic [47:0] pos;
    logic        busy;
    logic        done;
    logic [2:0]  lim;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;
  nav_position_unit_if #(.K(16), .AXES(3)) bus();
  nav_position_unit #(
    .K(16), .AXES(3),
    .ATTACK_SPEED(16'd3), .DEFENSE_SPEED(16'd5), .STEALTH_SPEED(16'd7),
    .WARP_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [47:0] p3(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {z, y, x};
  endfunction
  task automatic expect_out(input string tag, input logic [47:0] ep, input logic eb, input logic ed, input logic [2:0] el);
    exp_t e;
    e.tag  = tag;
    e.pos  = ep;
    e.busy = eb;
    e.done = ed;
    e.lim  = el;
    q.push_back(e);
  endtask
  task automatic step(input string tag, input logic [3:0] m, input logic mv, input logic [2:0] d,
                      input logic h, input logic jr, input logic [47:0] jp,
                      input logic [47:0] ep, input logic eb, input logic ed, input logic [2:0] el);
    @(negedge clk);
    bus.mode          = m;
    bus.move_en       = mv;
    bus.dir           = d;
    bus.home          = h;
    bus.jump_req      = jr;
    bus.jump_position = jp;
    expect_out(tag, ep, eb, ed, el);
  endtask
  task automatic jump_seq(input string tag, input logic [47:0] p, input logic [47:0] t, input logic [47:0] junk);
    step({tag, "_req"},  MA, 1'b0, 3'b000, 1'b0, 1'b1, t,    p, 1'b1, 1'b0, 3'b000);
    step({tag, "_chg1"}, MA, 1'b1, 3'b000, 1'b0, 1'b0, junk, p, 1'b1, 1'b0, 3'b000);
    step({tag, "_chg2"}, MA, 1'b1, 3'b000, 1'b0, 1'b1, junk, p, 1'b1, 1'b0, 3'b000);
    step({tag, "_chg3"}, MA, 1'b0, 3'b000, 1'b0, 1'b0, junk, p, 1'b1, 1'b0, 3'b000);
    step({tag, "_warp"}, MA, 1'b0, 3'b000, 1'b0, 1'b0, junk, p, 1'b1, 1'b0, 3'b000);
    step({tag, "_land"}, MA, 1'b0, 3'b000, 1'b0, 1'b0, junk, t, 1'b0, 1'b1, 3'b000);
    step({tag, "_post"}, MA, 1'b0, 3'b000, 1'b0, 1'b0, junk, t, 1'b0, 1'b0, 3'b000);
  endtask
  always @(posedge clk or posedge rst) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if (bus.position !== me.pos) begin
        errors++;
        $display("FAIL %s: pos=%h expected %h", me.tag, bus.position, me.pos);
      end
      if (bus.jump_busy !== me.busy) begin
        errors++;
        $display("FAIL %s: busy=%b expected %b", me.tag, bus.jump_busy, me.busy);
      end
      if (bus.jump_done !== me.done) begin
        errors++;
        $display("FAIL %s: done=%b expected %b", me.tag, bus.jump_done, me.done);
      end
      if (bus.at_limit !== me.lim) begin
        errors++;
        $display("FAIL %s: lim=%b expected %b", me.tag, bus.at_limit, me.lim);
      end
    end
    if (stim_done && q.size() == 0) begin
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end
  initial begin
    logic [47:0] t1, tx, s, p;
    logic [47:0] sat1_p, sat2_p;
    logic [2:0]  sat1_l, hold_l, sat2_l;
    t1 = p3(16'h0010, 16'h0100, 16'h0249);
    tx = p3(16'h1111, 16'h2222, 16'h3333);
    s  = p3(16'hFFFE, 16'h0002, 16'h0005);
`ifdef NAV_POSITION_WRAP_EN
    sat1_p = p3(16'h0001, 16'hFFFF, 16'h0002); sat1_l = 3'b011; hold_l = 3'b000;
    sat2_p = p3(16'h0004, 16'hFFFC, 16'hFFFF); sat2_l = 3'b100;
`else
    sat1_p = p3(16'hFFFF, 16'h0000, 16'h0002); sat1_l = 3'b011; hold_l = 3'b011;
    sat2_p = p3(16'hFFFF, 16'h0000, 16'h0000); sat2_l = 3'b111;
`endif
    rst               = 1'b1;
    bus.mode          = M0;
    bus.move_en       = 1'b0;
    bus.dir           = '0;
    bus.home          = 1'b0;
    bus.jump_req      = 1'b0;
    bus.jump_position = '0;
    #2;
    expect_out("reset", '0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++)
      step("fwd", MA, 1'b1, 3'b000, 1'b0, 1'b0, '0, p3(16'(3*i), 16'(3*i), 16'(3*i)), 1'b0, 1'b0, 3'b000);
    step("ydec1",    MA,      1'b1, 3'b010, 1'b0, 1'b0, '0, p3(18, 12, 18), 1'b0, 1'b0, 3'b000);
    step("ydec2",    MA,      1'b1, 3'b010, 1'b0, 1'b0, '0, p3(21, 9, 21),  1'b0, 1'b0, 3'b000);
    step("mode0110", 4'b0110, 1'b1, 3'b000, 1'b0, 1'b0, '0, p3(21, 9, 21),  1'b0, 1'b0, 3'b000);
    step("mode0001", M0,      1'b1, 3'b000, 1'b0, 1'b0, '0, p3(21, 9, 21),  1'b0, 1'b0, 3'b000);
    step("move_off", MA,      1'b0, 3'b000, 1'b0, 1'b0, '0, p3(21, 9, 21),  1'b0, 1'b0, 3'b000);
    step("defense",  MD,      1'b1, 3'b000, 1'b0, 1'b0, '0, p3(26, 14, 26), 1'b0, 1'b0, 3'b000);
    step("stealth",  MS,      1'b1, 3'b111, 1'b0, 1'b0, '0, p3(19, 7, 19),  1'b0, 1'b0, 3'b000);
    jump_seq("jump1", p3(19, 7, 19), t1, tx);
    jump_seq("jump2", t1, s, tx);
    step("sat1",     MA, 1'b1, 3'b110, 1'b0, 1'b0, '0, sat1_p, 1'b0, 1'b0, sat1_l);
    step("sat_hold", MA, 1'b0, 3'b110, 1'b0, 1'b0, '0, sat1_p, 1'b0, 1'b0, hold_l);
    step("sat2",     MA, 1'b1, 3'b110, 1'b0, 1'b0, '0, sat2_p, 1'b0, 1'b0, sat2_l);
    step("vel0",     M0, 1'b1, 3'b110, 1'b0, 1'b0, '0, sat2_p, 1'b0, 1'b0, 3'b000);
    step("home_vs_jump", MA, 1'b0, 3'b000, 1'b1, 1'b1, t1, '0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++)
      step("home_nojump", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    p = p3(3, 3, 3);
    step("abort_fwd",  MA, 1'b1, 3'b000, 1'b0, 1'b0, '0, p,  1'b0, 1'b0, 3'b000);
    step("abort_req",  MA, 1'b0, 3'b000, 1'b0, 1'b1, t1, p,  1'b1, 1'b0, 3'b000);
    step("abort_chg",  MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, p,  1'b1, 1'b0, 3'b000);
    step("abort_home", MA, 1'b0, 3'b000, 1'b1, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++)
      step("abort_idle", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    step("whome_fwd", MA, 1'b1, 3'b000, 1'b0, 1'b0, '0, p, 1'b0, 1'b0, 3'b000);
    step("whome_req", MA, 1'b0, 3'b000, 1'b0, 1'b1, t1, p, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("whome_chg", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, p, 1'b1, 1'b0, 3'b000);
    step("whome_home", MA, 1'b0, 3'b000, 1'b1, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    step("whome_idle", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    step("held_req", MA, 1'b0, 3'b000, 1'b0, 1'b1, t1, '0, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("held_chg", MA, 1'b0, 3'b000, 1'b0, 1'b1, t1, '0, 1'b1, 1'b0, 3'b000);
    step("held_land", MA, 1'b0, 3'b000, 1'b0, 1'b1, s,  t1, 1'b0, 1'b1, 3'b000);
    step("held_rereq", MA, 1'b0, 3'b000, 1'b0, 1'b1, s, t1, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("held_chg2", MA, 1'b0, 3'b000, 1'b0, 1'b0, tx, t1, 1'b1, 1'b0, 3'b000);
    step("held_land2", MA, 1'b0, 3'b000, 1'b0, 1'b0, tx, s, 1'b0, 1'b1, 3'b000);
    step("held_post",  MA, 1'b0, 3'b000, 1'b0, 1'b0, tx, s, 1'b0, 1'b0, 3'b000);
    step("arst_req", MA, 1'b0, 3'b000, 1'b0, 1'b1, t1, s, 1'b1, 1'b0, 3'b000);
    step("arst_chg", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, s, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    #2;
    expect_out("arst_async", '0, 1'b0, 1'b0, 3'b000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("arst_cruise", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, '0, 1'b0, 1'b0, 3'b000);
    step("arst_move",   MA, 1'b1, 3'b000, 1'b0, 1'b0, t1, p,  1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("arst_idle", MA, 1'b0, 3'b000, 1'b0, 1'b0, t1, p, 1'b0, 1'b0, 3'b000);
    stim_done = 1'b1;
  end
endmodule
